// File: rtl/multiplicador_secuencial.sv
// Iterative signed multiplier with a valid/ready handshake.
// The magnitudes of a and b are multiplied with one shift-add step per
// clock over N cycles. The sign is applied at the last step, and the single
// out-of-range result (min*min) is clamped so that the top two product bits
// always agree.
module multiplicador_secuencial #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST    = CW'(N - 1);
  localparam logic [N-1:0]   ONE_N   = N'(1);
  localparam logic [2*N-1:0] ONE_2N  = (2*N)'(1);
  // Largest positive value whose top two bits agree: 2'b00 followed by all ones.
  localparam logic [2*N-1:0] SAT_POS = {2'b00, {(2*N-2){1'b1}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   mcand_q, mcand_d;   // |a|, shifted left once per step
  logic [N-1:0]     mplier_q, mplier_d; // |b|, shifted right once per step
  logic             neg_q, neg_d;       // the result is negative
  logic [2*N-1:0]   acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   prod_q, prod_d;

  // Datapath helpers.
  logic [N-1:0]     mag_a, mag_b;
  logic [2*N-1:0]   acc_step, signed_res, final_res;

  // Magnitudes as N-bit unsigned values. -2^(N-1) maps to 2^(N-1), which still fits.
  always_comb begin
    mag_a = a[N-1] ? (~a + ONE_N) : a;
    mag_b = b[N-1] ? (~b + ONE_N) : b;
  end

  // One shift-add step, then the sign is applied and the min*min case is clamped.
  always_comb begin
    acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    signed_res = neg_q ? (~acc_step + ONE_2N) : acc_step;
    final_res  = (signed_res[2*N-1:2*N-2] == 2'b01) ? SAT_POS : signed_res;
  end

  // Next-state logic and datapath control for the three-state FSM.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{N{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = a[N-1] ^ b[N-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          prod_d  = final_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  // Both handshake outputs are decoded from the state register only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed and randomized checks for multiplicador_secuencial with N=16.
module tb_multiplicador_secuencial;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  a, b;
  logic [2*N-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  multiplicador_secuencial #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the exact product, with min*min clamped.
  function automatic logic [31:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    longint p;
    logic [63:0] u;
    p = longint'($signed(x)) * longint'($signed(y));
    if (p == 64'sd1073741824) p = 64'sd1073741823;
    u = p;
    return u[31:0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called while IDLE, 1 time unit after an edge. The operands are accepted at the next edge.
  task automatic accept(input logic [N-1:0] x, input logic [N-1:0] y);
    a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits out the latency while checking the handshake flags every cycle.
  task automatic wait_result(input string tag, input logic [31:0] exp);
    for (int i = 1; i < N; i++) begin
      tick();
      chk({tag, "_busy_ov"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_busy_ir"}, {31'b0, in_ready}, 32'd0);
    end
    tick();
    chk({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_prod"}, product, exp);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_ov"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_post_ir"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [31:0]  held;
    int gap;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_ir", {31'b0, in_ready}, 32'd1);
    chk("rst_ov", {31'b0, out_valid}, 32'd0);
    chk("rst_prod", product, 32'h0);
    #20 reset = 1'b0;
    tick();

    // Basic signed case with full latency and handshake checks.
    accept(16'd3, 16'hFFFC);
    chk("basic_ir0", {31'b0, in_ready}, 32'd0);
    wait_result("basic", 32'hFFFFFFF4);
    consume("basic");

    // Extremes, including the clamp.
    accept(16'h8000, 16'h7FFF); wait_result("min_max", 32'hC0008000); consume("min_max");
    accept(16'h7FFF, 16'h7FFF); wait_result("max_max", 32'h3FFF0001); consume("max_max");
    accept(16'h8000, 16'h8000); wait_result("min_min", 32'h3FFFFFFF); consume("min_min");
    accept(16'h0000, 16'h8000); wait_result("zero_min", 32'h00000000); consume("zero_min");

    // Backpressure with the operand inputs toggling during BUSY and DONE.
    accept(16'hFFFD, 16'h0100);
    for (int i = 1; i <= N; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
      tick();
    end
    chk("bp_ov", {31'b0, out_valid}, 32'd1);
    chk("bp_prod", product, 32'hFFFFFD00);
    for (int i = 0; i < 5; i++) begin
      a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
      tick();
      chk("bp_hold_ov", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_prod", product, 32'hFFFFFD00);
      chk("bp_hold_ir", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume("bp");
    tick();
    chk("bp_single_xfer", {31'b0, out_valid}, 32'd0);
    chk("bp_idle_prod", product, 32'hFFFFFD00);

    // Back-to-back operations: the second accept lands exactly N+2 edges after the first.
    out_ready = 1'b1; in_valid = 1'b1; a = 16'd5; b = 16'd7;
    tick();                                   // accept edge k
    chk("b2b_acc1", {31'b0, in_ready}, 32'd0);
    a = 16'hFFFE; b = 16'hFFF7;               // picked up at the next accept
    repeat (N) tick();                        // edge k+N
    chk("b2b_ov1", {31'b0, out_valid}, 32'd1);
    chk("b2b_prod1", product, 32'd35);
    tick();                                   // edge k+N+1: transfer
    chk("b2b_xfer1_ov", {31'b0, out_valid}, 32'd0);
    chk("b2b_xfer1_ir", {31'b0, in_ready}, 32'd1);
    tick();                                   // edge k+N+2: second accept
    in_valid = 1'b0;
    chk("b2b_acc2", {31'b0, in_ready}, 32'd0);
    repeat (N) tick();
    chk("b2b_ov2", {31'b0, out_valid}, 32'd1);
    chk("b2b_prod2", product, 32'd18);
    tick();
    out_ready = 1'b0;
    chk("b2b_xfer2_ov", {31'b0, out_valid}, 32'd0);

    // Reset asserted during BUSY step 7.
    accept(16'd100, 16'd200);
    repeat (7) tick();
    #2 reset = 1'b1;
    #1;
    chk("rmid_ov", {31'b0, out_valid}, 32'd0);
    chk("rmid_prod", product, 32'h0);
    chk("rmid_ir", {31'b0, in_ready}, 32'd1);
    #1 reset = 1'b0;
    tick();
    chk("rmid_no_ov", {31'b0, out_valid}, 32'd0);
    accept(16'hFFF9, 16'd6);
    wait_result("rmid_new", 32'hFFFFFFD6);
    consume("rmid_new");

    // Randomized operands with random out_ready gaps.
    for (int t = 0; t < 1000; t++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ra = 16'h8000;
      if ($urandom_range(0, 15) == 0) rb = 16'h8000;
      accept(ra, rb);
      repeat (N) tick();
      chk("rnd_ov", {31'b0, out_valid}, 32'd1);
      chk("rnd_prod", product, ref_mul(ra, rb));
      held = ref_mul(ra, rb);
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      chk("rnd_hold", product, held);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("rnd_post_ov", {31'b0, out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multiplicador_secuencial.md
# multiplicador_secuencial

Iterative signed fixed-point multiplier that produces the 2N-bit products consumed by the saturating adder (`sumador`) in the datapath. It accepts two N-bit two's-complement operands over a valid/ready handshake, computes one shift-add step per clock over N cycles, and presents a 2N-bit product. The product is conditioned so that bits 2N-1 and 2N-2 always agree, which is the sign-guard format the downstream adder's overflow detection expects.

## Interface
- N, default 16; instantiations pass `` `N `` from `constantes.h`. Operand width; product width is 2N.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  N  signed multiplicand.
- b  input  N  signed multiplier.
- out_valid  output  1  product is valid; held until consumed.
- out_ready  input  1  downstream accepts product.
- product  output  2N  signed product a*b, sign-guarded (see Operation).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. If in_valid=1 at a clock edge, register a and b, clear the accumulator, set step counter to 0, and go to BUSY.
- BUSY: one shift-add step per edge and counter+1. After the N-th step, go to DONE. Any algorithm is acceptable, for example sign-magnitude shift-add with final negate, or radix-2 Booth, provided the result is exact.
- DONE: out_valid=1 and product is stable. When out_valid & out_ready are both high at an edge, go to IDLE. No operand accept in DONE.
- a and b are sampled only at the accept edge. Changes to a or b during BUSY or DONE are ignored. in_valid is ignored outside IDLE.
- Arithmetic: exact 2N-bit two's-complement product, no rounding or truncation.
- Sign-guard rule: the only exact product whose top two bits differ is (-2^(N-1))*(-2^(N-1)) = 2^(2N-2). This case is clamped to 2^(2N-2)-1, which is 2'b00 followed by all ones. All other products are exact.
- product is driven from a register. It holds the last completed result in IDLE and BUSY, and it updates only on entry to DONE.
- Reset, asynchronous and taking effect immediately, from any state including mid-BUSY:
  - state goes to IDLE, so in_ready=1 (also during reset);
  - out_valid=0, product=0, counter=0, accumulator=0;
  - an aborted operation never produces out_valid.

## Timing
- Accept at edge k, where in_valid & in_ready are both high.
- out_valid rises after edge k+N, so latency is N cycles from accept to product valid.
- in_ready=0 from after edge k until the product is consumed.
- With out_ready tied high:
  - transfer occurs at edge k+N+1;
  - in_ready rises after edge k+N+1;
  - the next accept is at edge k+N+2;
  - throughput is one product per N+2 cycles.
- Backpressure: out_valid and product stay constant while out_ready=0, with no limit on duration.
- out_valid deasserts after the transfer edge. There are no combinational paths from inputs to outputs except in_ready, which is decoded from state only.

## Test plan
- Basic signed, N=16: a=3, b=-4 (0xFFFC), accepted at edge k -> out_valid after edge k+16, product=0xFFFFFFF4. in_ready is low throughout.
- Extremes: 0x8000*0x7FFF -> 0xC0008000. 0x7FFF*0x7FFF -> 0x3FFF0001. 0x8000*0x8000 -> clamped 0x3FFFFFFF. 0*0x8000 -> 0x00000000.
- Backpressure and operand isolation: hold out_ready=0 for 5 cycles after out_valid, and toggle a/b and in_valid during BUSY and DONE -> product unchanged, in_ready=0, exactly one transfer when out_ready=1.
- Back-to-back with out_ready=1 and in_valid=1: operand pairs (5,7) then (-2,-9) -> products 35 then 18, accepts exactly 18 cycles apart (N+2).
- Reset mid-operation: assert reset during step 7 of BUSY -> out_valid=0, product=0, in_ready=1 immediately. A new accept after release yields a correct result with no residue from the aborted operation.
- Randomized check: 1000 random a/b pairs with random out_ready gaps -> every product matches a reference model, including the clamp rule.
